// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_common / axi_lite_reg_slave                              |
// | Description : AXI-lite register-file slave with byte strobes, read-only    |
// |               registers and error responses for out-of-range addresses.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package axi_common;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;
endpackage

module axi_lite_reg_slave #(
    parameter int                             DATA_WIDTH  = 64,
    parameter int                             ADDR_WIDTH  = 12,
    parameter int                             NUM_REGS    = 8,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
    parameter axi_common::resp_t              OOR_RESP    = axi_common::RESP_DECERR
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [ADDR_WIDTH-1:0]          aw_addr,
    input  logic                           aw_valid,
    output logic                           aw_ready,
    input  logic [DATA_WIDTH-1:0]          w_data,
    input  logic [DATA_WIDTH/8-1:0]        w_strb,
    input  logic                           w_valid,
    output logic                           w_ready,
    output logic [1:0]                     b_resp,
    output logic                           b_valid,
    input  logic                           b_ready,
    input  logic [ADDR_WIDTH-1:0]          ar_addr,
    input  logic                           ar_valid,
    output logic                           ar_ready,
    output logic [DATA_WIDTH-1:0]          r_data,
    output logic [1:0]                     r_resp,
    output logic                           r_valid,
    input  logic                           r_ready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int                 c_STRB_W   = DATA_WIDTH / 8;
    localparam int                 c_LSB      = $clog2(c_STRB_W);
    localparam int                 c_IDX_W    = ADDR_WIDTH - c_LSB;
    localparam logic [c_IDX_W:0]   c_NUM_REGS = (c_IDX_W + 1)'(NUM_REGS);

    logic                  r_aw_full;
    logic [c_IDX_W-1:0]    r_aw_idx;
    logic                  r_w_full;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [c_STRB_W-1:0]   r_w_strb;
    logic                  r_b_valid;
    logic [1:0]            r_b_resp;
    logic                  r_r_valid;
    logic [DATA_WIDTH-1:0] r_r_data;
    logic [1:0]            r_r_resp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [c_STRB_W-1:0]   w_wr_strb;
    logic                  w_wr_in_range;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused_addr_bits;

    assign aw_ready = !r_aw_full && !r_b_valid;
    assign w_ready  = !r_w_full && !r_b_valid;
    assign ar_ready = !r_r_valid;
    assign b_valid  = r_b_valid;
    assign b_resp   = r_b_resp;
    assign r_valid  = r_r_valid;
    assign r_data   = r_r_data;
    assign r_resp   = r_r_resp;

    assign w_aw_hs  = aw_valid && aw_ready;
    assign w_w_hs   = w_valid && w_ready;
    assign w_ar_hs  = ar_valid && ar_ready;
    assign w_commit = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);

    // A buffered beat takes priority over the live bus for the commit operands
    assign w_wr_idx      = r_aw_full ? r_aw_idx : aw_addr[ADDR_WIDTH-1:c_LSB];
    assign w_wr_data     = r_w_full ? r_w_data : w_data;
    assign w_wr_strb     = r_w_full ? r_w_strb : w_strb;
    assign w_wr_in_range = {1'b0, w_wr_idx} < c_NUM_REGS;

    assign w_rd_idx      = ar_addr[ADDR_WIDTH-1:c_LSB];
    assign w_rd_in_range = {1'b0, w_rd_idx} < c_NUM_REGS;

    assign w_unused_addr_bits = ^{aw_addr[c_LSB-1:0], ar_addr[c_LSB-1:0]};

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == c_IDX_W'(i)) begin
                w_rd_data = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_b_valid <= 1'b0;
            r_b_resp  <= axi_common::RESP_OKAY;
        end else begin
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_b_valid <= 1'b1;
                r_b_resp  <= w_wr_in_range ? axi_common::RESP_OKAY : OOR_RESP;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_idx  <= aw_addr[ADDR_WIDTH-1:c_LSB];
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_w_data <= w_data;
                    r_w_strb <= w_strb;
                end
                if (r_b_valid && b_ready) begin
                    r_b_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= axi_common::RESP_OKAY;
        end else if (w_ar_hs) begin
            r_r_valid <= 1'b1;
            r_r_data  <= w_rd_data;
            r_r_resp  <= w_rd_in_range ? axi_common::RESP_OKAY : OOR_RESP;
        end else if (r_r_valid && r_ready) begin
            r_r_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_reg;
        logic                  r_pulse;
        logic                  w_hit;

        // Read-only registers never match, so they neither change nor pulse
        assign w_hit = w_commit && (w_wr_idx == c_IDX_W'(i)) && !RO_MASK[i];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_reg   <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_hit;
                if (w_hit) begin
                    for (int k = 0; k < c_STRB_W; k++) begin
                        if (w_wr_strb[k]) begin
                            r_reg[8*k +: 8] <= w_wr_data[8*k +: 8];
                        end
                    end
                end
            end
        end

        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = r_reg;
        assign wr_pulse[i]                        = r_pulse;
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_lite_reg_slave                                        |
// | Description : Directed bench for axi_lite_reg_slave (8 x 64-bit, reg 5 RO). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_axi_lite_reg_slave;

    localparam int DW = 64;
    localparam int AW = 12;
    localparam int NR = 8;

    localparam logic [NR*DW-1:0] c_RV = {
        64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666,
        64'h5555_5555_5555_5555, 64'h4444_4444_4444_4444,
        64'h3333_3333_3333_3333, 64'h0000_0000_0000_0000,
        64'h1111_1111_1111_1111, 64'h0123_4567_89AB_CDEF
    };
    localparam logic [NR-1:0] c_RO = 8'b0010_0000;

    logic            clk;
    logic            rstn;
    logic [AW-1:0]   aw_addr;
    logic            aw_valid;
    logic            aw_ready;
    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_strb;
    logic            w_valid;
    logic            w_ready;
    logic [1:0]      b_resp;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   ar_addr;
    logic            ar_valid;
    logic            ar_ready;
    logic [DW-1:0]   r_data;
    logic [1:0]      r_resp;
    logic            r_valid;
    logic            r_ready;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]   wr_pulse;

    axi_lite_reg_slave #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .NUM_REGS    (NR),
        .RESET_VALUE (c_RV),
        .RO_MASK     (c_RO),
        .OOR_RESP    (axi_common::RESP_DECERR)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .aw_addr  (aw_addr),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .w_data   (w_data),
        .w_strb   (w_strb),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .b_resp   (b_resp),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .ar_addr  (ar_addr),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .r_data   (r_data),
        .r_resp   (r_resp),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .regs_o   (regs_o),
        .wr_pulse (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    strb;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
        logic [NR-1:0] pulse;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rv(input int i);
        return c_RV[i*DW +: DW];
    endfunction

    task automatic do_write(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [7:0] strb, input logic [1:0] resp, input logic [NR-1:0] pulse);
        @(negedge clk);
        aw_addr = addr; aw_valid = 1'b1;
        w_data  = data; w_strb   = strb; w_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        check({name, " b_valid"}, b_valid, 1);
        check({name, " b_resp"}, b_resp, resp);
        check({name, " wr_pulse"}, wr_pulse, pulse);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check({name, " b_valid clr"}, b_valid, 0);
        check({name, " pulse clr"}, wr_pulse, 0);
    endtask

    task automatic do_read(input string name, input logic [AW-1:0] addr,
                           input logic [DW-1:0] exp_data, input logic [1:0] resp);
        @(negedge clk);
        ar_addr = addr; ar_valid = 1'b1;
        @(negedge clk);
        ar_valid = 1'b0;
        check({name, " r_valid"}, r_valid, 1);
        check({name, " r_data"}, r_data, exp_data);
        check({name, " r_resp"}, r_resp, resp);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check({name, " r_valid clr"}, r_valid, 0);
    endtask

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < NR; i++) begin
            vecs.push_back('{1'b0, AW'(i*8), 64'h0, 8'h00, 2'd0, rv(i), 8'h00});
        end
        vecs.push_back('{1'b1, 12'h008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2'd0, 64'h0, 8'h02});
        vecs.push_back('{1'b0, 12'h008, 64'h0, 8'h00, 2'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'h00});
        vecs.push_back('{1'b1, 12'h018, 64'hAABB_CCDD_EEFF_0011, 8'hA5, 2'd0, 64'h0, 8'h08});
        vecs.push_back('{1'b0, 12'h01C, 64'h0, 8'h00, 2'd0, 64'hAA33_CC33_33FF_3311, 8'h00});
        vecs.push_back('{1'b1, 12'h020, 64'h9999_9999_9999_9999, 8'h00, 2'd0, 64'h0, 8'h10});
        vecs.push_back('{1'b0, 12'h020, 64'h0, 8'h00, 2'd0, rv(4), 8'h00});
        vecs.push_back('{1'b1, 12'h028, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd0, 64'h0, 8'h00});
        vecs.push_back('{1'b0, 12'h028, 64'h0, 8'h00, 2'd0, rv(5), 8'h00});
        vecs.push_back('{1'b1, 12'h040, 64'h1234_5678_9ABC_DEF0, 8'hFF, 2'd3, 64'h0, 8'h00});
        vecs.push_back('{1'b0, 12'h040, 64'h0, 8'h00, 2'd3, 64'h0, 8'h00});
        vecs.push_back('{1'b0, 12'hFF8, 64'h0, 8'h00, 2'd3, 64'h0, 8'h00});

        rstn = 1'b0;
        aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0;
        b_ready = 1'b0; ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst aw_ready", aw_ready, 1);
        check("rst w_ready", w_ready, 1);
        check("rst ar_ready", ar_ready, 1);
        check("rst b_valid", b_valid, 0);
        check("rst r_valid", r_valid, 0);
        check("rst r_data", r_data, 0);
        check("rst wr_pulse", wr_pulse, 0);
        check("rst regs_o", regs_o, c_RV);
        rstn = 1'b1;

        foreach (vecs[n]) begin
            if (vecs[n].wr)
                do_write($sformatf("vec%0d wr", n), vecs[n].addr, vecs[n].data, vecs[n].strb,
                         vecs[n].resp, vecs[n].pulse);
            else
                do_read($sformatf("vec%0d rd", n), vecs[n].addr, vecs[n].rdata, vecs[n].resp);
        end

        // W first, AW three cycles later
        @(negedge clk);
        check("wfirst w_ready pre", w_ready, 1);
        w_data = 64'h1122_3344_5566_7788; w_strb = 8'h0F; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("wfirst w_ready stall", w_ready, 0);
            check("wfirst aw_ready", aw_ready, 1);
            check("wfirst b_valid", b_valid, 0);
            if (c == 2) begin
                aw_addr = 12'h010; aw_valid = 1'b1;
            end
            @(negedge clk);
        end
        aw_valid = 1'b0;
        check("wfirst b_valid", b_valid, 1);
        check("wfirst b_resp", b_resp, 0);
        check("wfirst wr_pulse", wr_pulse, 8'h04);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("wfirst reg2", regs_o[2*DW +: DW], 64'h0000_0000_5566_7788);
        check("wfirst b_valid clr", b_valid, 0);

        // B and R backpressure
        @(negedge clk);
        aw_addr = 12'h030; aw_valid = 1'b1;
        w_data = 64'h0F0F_0F0F_0F0F_0F0F; w_strb = 8'hFF; w_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bstall b_valid", b_valid, 1);
            check("bstall b_resp", b_resp, 0);
            check("bstall aw_ready", aw_ready, 0);
            check("bstall w_ready", w_ready, 0);
            @(negedge clk);
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("bstall b_valid clr", b_valid, 0);
        ar_addr = 12'h030; ar_valid = 1'b1;
        @(negedge clk);
        ar_addr = 12'h000;
        for (int c = 0; c < 5; c++) begin
            check("rstall r_valid", r_valid, 1);
            check("rstall r_data", r_data, 64'h0F0F_0F0F_0F0F_0F0F);
            check("rstall ar_ready", ar_ready, 0);
            @(negedge clk);
        end
        ar_valid = 1'b0; r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("rstall r_valid clr", r_valid, 0);

        // Same-edge read and write of reg 0 returns the old value
        aw_addr = 12'h000; aw_valid = 1'b1;
        w_data = 64'hFEDC_BA98_7654_3210; w_strb = 8'hFF; w_valid = 1'b1;
        ar_addr = 12'h000; ar_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        check("rw r_data old", r_data, rv(0));
        check("rw b_valid", b_valid, 1);
        check("rw reg0 new", regs_o[DW-1:0], 64'hFEDC_BA98_7654_3210);
        b_ready = 1'b1; r_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0; r_ready = 1'b0;

        // Reset with AW buffered and R pending
        aw_addr = 12'h008; aw_valid = 1'b1;
        ar_addr = 12'h018; ar_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0; ar_valid = 1'b0;
        check("mid aw_ready", aw_ready, 0);
        check("mid r_valid", r_valid, 1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("mrst r_valid", r_valid, 0);
        check("mrst b_valid", b_valid, 0);
        check("mrst aw_ready", aw_ready, 1);
        check("mrst w_ready", w_ready, 1);
        check("mrst ar_ready", ar_ready, 1);
        check("mrst regs_o", regs_o, c_RV);
        w_data = 64'hAAAA_AAAA_AAAA_AAAA; w_strb = 8'hFF; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        check("mrst w only w_ready", w_ready, 0);
        check("mrst w only b_valid", b_valid, 0);
        @(negedge clk);
        check("mrst w only b_valid2", b_valid, 0);
        check("mrst w only pulse", wr_pulse, 0);
        check("mrst w only reg1", regs_o[DW +: DW], rv(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
